// File: rtl/fetcher_pkg.sv
// Shared types for the instruction-fetch stage: fault codes, FSM states and the substitute NOP.
package fetcher_pkg;

  typedef enum logic [1:0] {
    FF_NONE       = 2'd0,
    FF_MISALIGNED = 2'd1,
    FF_BUS_ERR    = 2'd2,
    FF_TIMEOUT    = 2'd3
  } fetch_fault_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetcher_if.sv
// AXI4-Lite-style read channel between the fetch stage (master) and instruction memory (slave).
interface fetcher_if;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    output m_araddr, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_araddr, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/fetcher.sv
// Instruction-fetch stage: one bus read per start pulse, result published with a one-cycle pulse.
//   state | meaning
//   IDLE  | waiting for enabled; ADDR  | arvalid up, waiting for arready
//   DATA  | rready up, waiting for rvalid; DONE | completed pulse, results valid
module fetcher
  import fetcher_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         enabled,
  output logic         completed,
  input  logic [31:0]  fetch_pc,
  output logic [31:0]  pc,
  output logic [31:0]  instr_raw,
  output fetch_fault_t fault,
  fetcher_if.master    bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  fetch_state_t state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [31:0]   araddr_q, araddr_next;
  logic [31:0]   pc_next, instr_next;
  fetch_fault_t  fault_next;
  logic          aligned, ar_hs, r_hs, expired;

  assign aligned       = (fetch_pc[1:0] == 2'b00);
  assign ar_hs         = bus.m_arvalid && bus.m_arready;
  assign r_hs          = bus.m_rvalid && bus.m_rready;
  assign expired       = (timer == TIMER_LAST);
  assign bus.m_araddr  = araddr_q;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enabled) state_next = aligned ? ADDR : DONE;
      ADDR: begin
        if (ar_hs)        state_next = DATA;
        else if (expired) state_next = DONE;
      end
      DATA: if (r_hs || expired) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake strobes decode the registered state; datapath next-values are computed alongside.
  always_comb begin
    completed     = (state == DONE);
    bus.m_arvalid = (state == ADDR);
    bus.m_rready  = (state == DATA);
    araddr_next   = araddr_q;
    pc_next       = pc;
    instr_next    = instr_raw;
    fault_next    = fault;
    timer_next    = (timer == '1) ? timer : timer + 1'b1;
    case (state)
      IDLE: begin
        timer_next = '0;
        if (enabled) begin
          if (aligned) begin
            araddr_next = fetch_pc;
          end else begin
            pc_next    = fetch_pc;
            instr_next = FETCH_NOP;
            fault_next = FF_MISALIGNED;
          end
        end
      end
      ADDR: begin
        if (ar_hs) begin
          timer_next = '0;
        end else if (expired) begin
          pc_next    = araddr_q;
          instr_next = FETCH_NOP;
          fault_next = FF_TIMEOUT;
        end
      end
      DATA: begin
        if (r_hs) begin
          pc_next = araddr_q;
          if (bus.m_rresp == 2'b00) begin
            instr_next = bus.m_rdata;
            fault_next = FF_NONE;
          end else begin
            instr_next = FETCH_NOP;
            fault_next = FF_BUS_ERR;
          end
        end else if (expired) begin
          pc_next    = araddr_q;
          instr_next = FETCH_NOP;
          fault_next = FF_TIMEOUT;
        end
      end
      DONE: timer_next = '0;
      default: timer_next = '0;
    endcase
  end

  // pc/instr_raw/fault are published only as a fetch ends, so they hold steady otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer     <= '0;
      araddr_q  <= '0;
      pc        <= '0;
      instr_raw <= FETCH_NOP;
      fault     <= FF_NONE;
    end else begin
      timer     <= timer_next;
      araddr_q  <= araddr_next;
      pc        <= pc_next;
      instr_raw <= instr_next;
      fault     <= fault_next;
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: zero-wait, backpressure, misaligned, bus error, timeout, reset/busy.
module tb_fetcher;
  import fetcher_pkg::*;

  logic         clk = 1'b0;
  logic         rstn;
  logic         enabled;
  logic         completed;
  logic [31:0]  fetch_pc;
  logic [31:0]  pc;
  logic [31:0]  instr_raw;
  fetch_fault_t fault;

  int checks = 0;
  int errors = 0;
  int comp_count = 0;
  int hs_count = 0;
  int c0, h0;

  fetcher_if bus_if ();

  fetcher #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enabled   (enabled),
    .completed (completed),
    .fetch_pc  (fetch_pc),
    .pc        (pc),
    .instr_raw (instr_raw),
    .fault     (fault),
    .bus       (bus_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (completed === 1'b1) comp_count <= comp_count + 1;
    if (bus_if.m_arvalid === 1'b1 && bus_if.m_arready === 1'b1) hs_count <= hs_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_completed"}, 32'(completed), 32'd0);
    chk({tag, "_arvalid"}, 32'(bus_if.m_arvalid), 32'd0);
    chk({tag, "_rready"}, 32'(bus_if.m_rready), 32'd0);
    chk({tag, "_araddr"}, bus_if.m_araddr, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instr_raw, 32'h0000_0013);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; enabled = 1'b0; fetch_pc = '0;
    bus_if.m_arready = 1'b0; bus_if.m_rvalid = 1'b0;
    bus_if.m_rdata = '0; bus_if.m_rresp = 2'b00;
    step(); step();
    rstn = 1'b1;
    chk_reset_vals("reset");

    // 1: zero-wait aligned fetch
    fetch_pc = 32'h100; enabled = 1'b1; bus_if.m_arready = 1'b1;
    step();
    enabled = 1'b0;
    chk("t1_arvalid", 32'(bus_if.m_arvalid), 32'd1);
    chk("t1_araddr", bus_if.m_araddr, 32'h100);
    chk("t1_comp_addr", 32'(completed), 32'd0);
    chk("t1_pc_held", pc, 32'h0);
    bus_if.m_rvalid = 1'b1; bus_if.m_rdata = 32'h0050_0093; bus_if.m_rresp = 2'b00;
    step();
    chk("t1_rready", 32'(bus_if.m_rready), 32'd1);
    chk("t1_arvalid_low", 32'(bus_if.m_arvalid), 32'd0);
    chk("t1_comp_data", 32'(completed), 32'd0);
    step();
    bus_if.m_rvalid = 1'b0; bus_if.m_arready = 1'b0;
    chk("t1_completed", 32'(completed), 32'd1);
    chk("t1_pc", pc, 32'h100);
    chk("t1_instr", instr_raw, 32'h0050_0093);
    chk("t1_fault", 32'(fault), 32'(FF_NONE));
    step();
    chk("t1_comp_drop", 32'(completed), 32'd0);
    chk("t1_instr_hold", instr_raw, 32'h0050_0093);

    // 2: backpressure, rvalid arriving on the last DATA cycle before timeout
    c0 = comp_count;
    fetch_pc = 32'h200; enabled = 1'b1;
    step();
    enabled = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_arvalid_hold", 32'(bus_if.m_arvalid), 32'd1);
      chk("t2_araddr_hold", bus_if.m_araddr, 32'h200);
      step();
    end
    bus_if.m_arready = 1'b1;
    chk("t2_arvalid_hs", 32'(bus_if.m_arvalid), 32'd1);
    step();
    bus_if.m_arready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("t2_rready_hold", 32'(bus_if.m_rready), 32'd1);
      chk("t2_comp_wait", 32'(completed), 32'd0);
      step();
    end
    bus_if.m_rvalid = 1'b1; bus_if.m_rdata = 32'h1234_5678; bus_if.m_rresp = 2'b00;
    step();
    bus_if.m_rvalid = 1'b0;
    chk("t2_completed", 32'(completed), 32'd1);
    chk("t2_instr", instr_raw, 32'h1234_5678);
    chk("t2_fault", 32'(fault), 32'(FF_NONE));
    chk("t2_pc", pc, 32'h200);
    step(); step();
    chk("t2_comp_once", 32'(comp_count), 32'(c0 + 1));

    // 3: misaligned address, no bus traffic
    h0 = hs_count;
    fetch_pc = 32'h102; enabled = 1'b1; bus_if.m_arready = 1'b1;
    step();
    enabled = 1'b0;
    chk("t3_completed", 32'(completed), 32'd1);
    chk("t3_arvalid", 32'(bus_if.m_arvalid), 32'd0);
    chk("t3_fault", 32'(fault), 32'(FF_MISALIGNED));
    chk("t3_instr", instr_raw, 32'h0000_0013);
    chk("t3_pc", pc, 32'h102);
    step();
    chk("t3_arvalid_after", 32'(bus_if.m_arvalid), 32'd0);
    chk("t3_comp_drop", 32'(completed), 32'd0);
    chk("t3_no_hs", 32'(hs_count), 32'(h0));

    // 4: bus error response
    fetch_pc = 32'h300; enabled = 1'b1;
    step();
    enabled = 1'b0;
    bus_if.m_rvalid = 1'b1; bus_if.m_rdata = 32'hDEAD_BEEF; bus_if.m_rresp = 2'b10;
    step();
    step();
    bus_if.m_rvalid = 1'b0; bus_if.m_arready = 1'b0; bus_if.m_rresp = 2'b00;
    chk("t4_completed", 32'(completed), 32'd1);
    chk("t4_fault", 32'(fault), 32'(FF_BUS_ERR));
    chk("t4_instr", instr_raw, 32'h0000_0013);
    chk("t4_pc", pc, 32'h300);
    step();

    // 5: address-phase timeout after 8 cycles, then a clean fetch
    fetch_pc = 32'h400; enabled = 1'b1;
    step();
    enabled = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_arvalid_hold", 32'(bus_if.m_arvalid), 32'd1);
      step();
    end
    chk("t5_arvalid_drop", 32'(bus_if.m_arvalid), 32'd0);
    chk("t5_completed", 32'(completed), 32'd1);
    chk("t5_fault", 32'(fault), 32'(FF_TIMEOUT));
    chk("t5_instr", instr_raw, 32'h0000_0013);
    chk("t5_pc", pc, 32'h400);
    step();
    fetch_pc = 32'h104; enabled = 1'b1; bus_if.m_arready = 1'b1;
    step();
    enabled = 1'b0;
    bus_if.m_rvalid = 1'b1; bus_if.m_rdata = 32'hABCD_0001; bus_if.m_rresp = 2'b00;
    step();
    step();
    bus_if.m_rvalid = 1'b0; bus_if.m_arready = 1'b0;
    chk("t5b_completed", 32'(completed), 32'd1);
    chk("t5b_instr", instr_raw, 32'hABCD_0001);
    chk("t5b_fault", 32'(fault), 32'(FF_NONE));
    chk("t5b_pc", pc, 32'h104);
    step();

    // 6: enabled while busy is dropped; reset in DATA abandons the read
    h0 = hs_count;
    c0 = comp_count;
    fetch_pc = 32'h500; enabled = 1'b1;
    step();
    fetch_pc = 32'h600;
    step();
    enabled = 1'b0;
    chk("t6_araddr_busy", bus_if.m_araddr, 32'h500);
    bus_if.m_arready = 1'b1;
    step();
    bus_if.m_arready = 1'b0;
    chk("t6_in_data", 32'(bus_if.m_rready), 32'd1);
    chk("t6_one_hs", 32'(hs_count), 32'(h0 + 1));
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk_reset_vals("t6_rst");
    bus_if.m_rvalid = 1'b1; bus_if.m_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_late_rready", 32'(bus_if.m_rready), 32'd0);
      chk("t6_late_instr", instr_raw, 32'h0000_0013);
      chk("t6_late_arvalid", 32'(bus_if.m_arvalid), 32'd0);
    end
    bus_if.m_rvalid = 1'b0;
    chk("t6_no_complete", 32'(comp_count), 32'(c0));
    chk("t6_hs_total", 32'(hs_count), 32'(h0 + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
